// File: rtl/shared_reg_pkg.sv
// Shared-register mailbox package: state encoding and size defaults.
//   DATA_W    : width of the mailbox byte
//   CNT_W_DEF : default width of the completed-write counter
//   state_e   : mailbox occupancy state
package shared_reg_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector (combinational).
//   req0, req1 : active requests
//   last       : index of the requester granted most recently
//   gnt0, gnt1 : one-hot grant, or zero when nobody requests
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt0,
    output logic gnt1
);

    // Under contention the requester not granted last wins; otherwise the lone requester wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            gnt0 = last;
            gnt1 = !last;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule

// File: rtl/shared_reg_arb.sv
// Single-byte mailbox shared by two writers and one reader.
//   clk, nrst           : clock, asynchronous active-low reset
//   req0/1, wr_data0/1  : writer requests and data
//   ack0/1              : one-cycle pulse after a writer's byte is captured
//   rd, rd_data         : read request and last byte read
//   rd_valid            : one-cycle pulse after rd_data is updated
//   has_data, src       : mailbox full flag and index of the writer that filled it
//   xfer_cnt            : completed writes (wraps)
//   underrun            : sticky flag, read attempted while empty
module shared_reg_arb
    import shared_reg_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req0,
    input  logic [DATA_W-1:0] wr_data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] wr_data1,
    output logic              ack1,
    input  logic              rd,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              has_data,
    output logic              src,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              underrun
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               src_q, src_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               underrun_q, underrun_d;
    logic               last_q, last_d;
    logic               armed_q, armed_d;
    logic               gnt0, gnt1;

    rr_arb2 u_rr_arb2 (
        .req0 (req0),
        .req1 (req1),
        .last (last_q),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_EMPTY;
            data_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            src_q      <= 1'b0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
            last_q     <= 1'b1;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            src_q      <= src_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
            last_q     <= last_d;
            armed_q    <= armed_d;
        end
    end

    // Next-state logic. Grants only happen in EMPTY and reads only in FULL,
    // so a byte can never be written and read on the same edge.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        src_d      = src_q;
        cnt_d      = cnt_q;
        underrun_d = underrun_q;
        last_d     = last_q;
        // armed_q masks grants on the first edge after reset release.
        armed_d    = 1'b1;

        case (state_q)
            ST_EMPTY: begin
                if (rd) begin
                    underrun_d = 1'b1;
                end
                if (armed_q && (gnt0 || gnt1)) begin
                    state_d = ST_FULL;
                    data_d  = gnt1 ? wr_data1 : wr_data0;
                    src_d   = gnt1;
                    last_d  = gnt1;
                    ack0_d  = gnt0;
                    ack1_d  = gnt1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_FULL: begin
                if (rd) begin
                    state_d    = ST_EMPTY;
                    rd_data_d  = data_q;
                    rd_valid_d = 1'b1;
                end
            end
        endcase
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign has_data = (state_q == ST_FULL);
    assign src      = src_q;
    assign xfer_cnt = cnt_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_shared_reg_arb.sv
// Self-checking bench for shared_reg_arb: directed scenarios followed by
// random writer/reader traffic, all checked against a transaction-level model.
module tb_shared_reg_arb;

    logic       clk = 1'b0;
    logic       nrst;
    logic       req0, req1, rd;
    logic [7:0] wd0, wd1;
    logic       ack0, ack1, rd_valid, has_data, src, underrun;
    logic [7:0] rd_data;
    logic [7:0] xfer_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the mailbox
    bit       m_full, m_src, m_last, m_under, m_first;
    bit       e_ack0, e_ack1, e_rv;
    bit [7:0] m_byte, m_rd_data;
    int       m_cnt;

    shared_reg_arb #(.CNT_W(8)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .req0     (req0),
        .wr_data0 (wd0),
        .ack0     (ack0),
        .req1     (req1),
        .wr_data1 (wd1),
        .ack1     (ack1),
        .rd       (rd),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .has_data (has_data),
        .src      (src),
        .xfer_cnt (xfer_cnt),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_byte = 0; m_rd_data = 0; m_src = 0; m_last = 1;
        m_under = 0; m_cnt = 0; e_ack0 = 0; e_ack1 = 0; e_rv = 0;
        m_first = 1;
    endtask

    // One rising edge of the mailbox, from the rules: writers fill an empty
    // box (round-robin on contention), the reader empties a full box.
    task automatic model_edge();
        bit w;
        e_ack0 = 0; e_ack1 = 0; e_rv = 0;
        if (!m_full) begin
            if (rd) m_under = 1;
            if (!m_first && (req0 || req1)) begin
                if (req0 && req1) w = !m_last;
                else              w = req1;
                m_byte = w ? wd1 : wd0;
                m_src  = w;
                m_last = w;
                m_full = 1;
                m_cnt  = (m_cnt + 1) % 256;
                if (w) e_ack1 = 1; else e_ack0 = 1;
            end
        end else if (rd) begin
            m_rd_data = m_byte;
            e_rv      = 1;
            m_full    = 0;
        end
        m_first = 0;
    endtask

    task automatic check_all();
        chk("ack0",     32'(ack0),     32'(e_ack0));
        chk("ack1",     32'(ack1),     32'(e_ack1));
        chk("rd_valid", 32'(rd_valid), 32'(e_rv));
        chk("rd_data",  32'(rd_data),  32'(m_rd_data));
        chk("has_data", 32'(has_data), 32'(m_full));
        chk("src",      32'(src),      32'(m_src));
        chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
        chk("underrun", 32'(underrun), 32'(m_under));
    endtask

    // Inputs are driven on the falling edge; outputs checked 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        nrst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic drive_random();
        if (req0) begin
            if (e_ack0) begin
                if ($urandom_range(1) == 1) wd0 = 8'($urandom);
                else                        req0 = 1'b0;
            end
        end else if ($urandom_range(2) == 0) begin
            req0 = 1'b1;
            wd0  = 8'($urandom);
        end
        if (req1) begin
            if (e_ack1) begin
                if ($urandom_range(1) == 1) wd1 = 8'($urandom);
                else                        req1 = 1'b0;
            end
        end else if ($urandom_range(2) == 0) begin
            req1 = 1'b1;
            wd1  = 8'($urandom);
        end
        rd = ($urandom_range(2) == 0);
    endtask

    logic [7:0] exp_d [4];
    bit         exp_s [4];

    initial begin
        exp_d = '{8'h11, 8'h22, 8'h11, 8'h22};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
        nrst = 1'b0; req0 = 0; req1 = 0; rd = 0; wd0 = 0; wd1 = 0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(negedge clk);

        // Single writer; request already high at reset release must not be granted on the first edge
        nrst = 1'b1;
        req0 = 1'b1; wd0 = 8'h5A;
        step();
        chk("first_edge_no_ack", 32'(ack0), 32'd0);
        step();
        chk("single_ack0", 32'(ack0), 32'd1);
        chk("single_full", 32'(has_data), 32'd1);
        chk("single_src", 32'(src), 32'd0);
        req0 = 1'b0; rd = 1'b1;
        step();
        chk("single_rv", 32'(rd_valid), 32'd1);
        chk("single_rd", 32'(rd_data), 32'h5A);
        chk("single_empty", 32'(has_data), 32'd0);
        rd = 1'b0;
        step();

        // Contention: writer 0 wins first after reset, then alternation
        apply_reset();
        step();
        req0 = 1'b1; wd0 = 8'h11; req1 = 1'b1; wd1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_src", 32'(src), 32'(exp_s[i]));
            rd = 1'b1;
            step();
            chk("rr_rv", 32'(rd_valid), 32'd1);
            chk("rr_data", 32'(rd_data), 32'(exp_d[i]));
            rd = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
        step();

        // Back-pressure: writer 1 waits while the box is full
        req0 = 1'b1; wd0 = 8'h33;
        step();
        req0 = 1'b0; req1 = 1'b1; wd1 = 8'h44;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_no_ack1", 32'(ack1), 32'd0);
        end
        rd = 1'b1;
        step();
        chk("bp_old_byte", 32'(rd_data), 32'h33);
        rd = 1'b0;
        step();
        chk("bp_ack1", 32'(ack1), 32'd1);
        chk("bp_src", 32'(src), 32'd1);
        req1 = 1'b0;

        // Underrun: drain, then read while empty
        rd = 1'b1;
        step();
        chk("ur_drain", 32'(rd_data), 32'h44);
        step();
        chk("ur_flag", 32'(underrun), 32'd1);
        chk("ur_rv", 32'(rd_valid), 32'd0);
        chk("ur_rd_hold", 32'(rd_data), 32'h44);
        rd = 1'b0;
        repeat (3) step();
        chk("ur_sticky", 32'(underrun), 32'd1);

        // Counter wrap over 256 write/read pairs
        apply_reset();
        step();
        for (int i = 0; i < 256; i++) begin
            req0 = 1'b1; wd0 = 8'(i);
            step();
            req0 = 1'b0; rd = 1'b1;
            step();
            rd = 1'b0;
            if (i == 254) chk("wrap_255", 32'(xfer_cnt), 32'd255);
        end
        chk("wrap_zero", 32'(xfer_cnt), 32'd0);

        // Asynchronous reset mid-cycle with ack1 pending
        req1 = 1'b1; wd1 = 8'h77;
        step();
        chk("ar_ack_pending", 32'(ack1), 32'd1);
        #2;
        nrst = 1'b0;
        req1 = 1'b0;
        #1;
        chk("ar_ack1", 32'(ack1), 32'd0);
        chk("ar_ack0", 32'(ack0), 32'd0);
        chk("ar_rv", 32'(rd_valid), 32'd0);
        chk("ar_rd_data", 32'(rd_data), 32'd0);
        chk("ar_has_data", 32'(has_data), 32'd0);
        chk("ar_src", 32'(src), 32'd0);
        chk("ar_cnt", 32'(xfer_cnt), 32'd0);
        chk("ar_underrun", 32'(underrun), 32'd0);
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        step();

        // Random traffic with one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) apply_reset();
            drive_random();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_reg_arb.md
SHARED_REG_ARB -- requirements
Module: shared_reg_arb

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the transfer counter.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port nrst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req0, input, 1 bit: writer 0 requests a write.
REQ-005 The block SHALL have port wr_data0, input, 8 bits: writer 0 data, stable while req0=1.
REQ-006 The block SHALL have port ack0, output, 1 bit: one-cycle pulse; writer 0 data captured.
REQ-007 The block SHALL have port req1, input, 1 bit: writer 1 requests a write.
REQ-008 The block SHALL have port wr_data1, input, 8 bits: writer 1 data, stable while req1=1.
REQ-009 The block SHALL have port ack1, output, 1 bit: one-cycle pulse; writer 1 data captured.
REQ-010 The block SHALL have port rd, input, 1 bit: reader requests the stored byte.
REQ-011 The block SHALL have port rd_data, output, 8 bits: last byte read.
REQ-012 The block SHALL have port rd_valid, output, 1 bit: one-cycle pulse; rd_data updated.
REQ-013 The block SHALL have port has_data, output, 1 bit: mailbox full.
REQ-014 The block SHALL have port src, output, 1 bit: requester index of the byte currently held.
REQ-015 The block SHALL have port xfer_cnt, output, CNT_W bits: completed writes.
REQ-016 The block SHALL have port underrun, output, 1 bit: sticky; rd issued while mailbox empty.

Function
REQ-017 The FSM SHALL have two states: EMPTY (has_data=0) and FULL (has_data=1).
REQ-018 In EMPTY with req0 or req1 high, the block SHALL grant exactly one requester on that edge.
REQ-019 On a grant, the block SHALL capture wr_dataN, set src=N and go to FULL.
REQ-020 On a grant, the block SHALL pulse ackN for exactly the following cycle (1-cycle latency).
REQ-021 When one requester is active it SHALL be granted; with both active, the one not granted last SHALL win (round-robin).
REQ-022 The last-grant pointer SHALL reset to 1, so writer 0 wins the first contention.
REQ-023 A requester SHALL drop or renew reqN on the edge at which it samples ackN=1; reqN high in the next cycle is a new request.
REQ-024 In FULL, no grant SHALL occur; requests SHALL wait with no ack.
REQ-025 In FULL with rd=1, the block SHALL copy the stored byte to rd_data, pulse rd_valid the next cycle and go to EMPTY.
REQ-026 A grant in EMPTY and a read in FULL are mutually exclusive, so a byte SHALL never be written and read on the same edge.
REQ-027 The first grant SHALL be possible on the edge after the read completes (EMPTY reached).
REQ-028 In EMPTY with rd=1, rd_data SHALL be unchanged, rd_valid SHALL stay 0 and underrun SHALL set and hold until reset.
REQ-029 xfer_cnt SHALL increment by 1 on every grant and wrap modulo 2^CNT_W (e.g. 255 -> 0 at CNT_W=8).
REQ-030 rd_data SHALL hold its value between reads.

Reset
REQ-031 On nrst=0, asynchronously: state=EMPTY, has_data=0, stored byte=0, rd_data=0, rd_valid=0, ack0=ack1=0, src=0, xfer_cnt=0, underrun=0, last-grant=1.
REQ-032 Reset asserted mid-transfer SHALL discard the stored byte and kill any pending ack/rd_valid pulse immediately.
REQ-033 No grant SHALL occur on the first rising edge coinciding with nrst deassertion.

Structure
REQ-034 Package shared_reg_pkg SHALL hold the EMPTY/FULL state encoding and the CNT_W default.
REQ-035 Round-robin selection SHALL be a sub-module rr_arb2 (inputs req0, req1, last; outputs gnt0, gnt1, one-hot or zero).

Verification
REQ-036 Single writer: req0=1, wr_data0=0x5A -> ack0 the next cycle, has_data=1, src=0; rd=1 -> rd_valid pulse, rd_data=0x5A, has_data=0.
REQ-037 Contention: req0=req1=1 with 0x11/0x22 and four reads -> order 0x11, 0x22, 0x11, 0x22, with src alternating 0, 1, 0, 1.
REQ-038 Back-pressure: mailbox FULL, req1=1 for 10 cycles -> no ack1; rd -> ack1 follows, and rd_data returns the old byte.
REQ-039 Underrun: rd=1 in EMPTY -> underrun=1 and held, rd_valid=0, rd_data unchanged.
REQ-040 Wrap: 256 write/read pairs -> xfer_cnt returns to 0.
REQ-041 Async reset: nrst pulse mid-cycle while FULL with ack pending -> all outputs 0 at once, without waiting for clk.
